in_spike_buf_pp: RTL and testbench

- Ping-pong input spike buffer feeding the neuron crossbar.
- Spikes from the router are written into a fill bank during a timestep. On start_i the banks swap; the crossbar then reads the previous timestep's spikes from the recall bank over several parallel channels.
- Generalises the single-bit recall/learn buffer to multi-bit spike values, selectable accumulate mode, N recall read channels, a clear sweep with write backpressure, and a per-timestep spike count.

---
 rtl/in_spike_buf_pp.sv | 185 ++++++++++++++++++
 tb/tb_in_spike_buf_pp.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/in_spike_buf_pp.sv
// Purpose : ping-pong input spike buffer (fill/recall banks plus a learn bank) feeding the neuron crossbar.
// Latency : writes take effect at the accepting edge; recall and learn reads return data one cycle after enable.
// Backpr. : wrRdy_o drops for the NUM_AXONS-cycle clear sweep after each swap; the source holds the write until accepted.
//
// Ports:
//   clk_i, rst_i (sync, active high)
//   start_i / busy_o / startErr_o                        timestep swap request, sweep status, sticky late-start flag
//   wrEn_i / wrRdy_o / wrAxonAddr_i / wrSpike_i          spike write handshake into the fill bank
//   rdEn_RclInSpike_i / RclAxonAddr_i / Rcl_InSpike_o / Rcl_valid_o   packed per-channel recall reads
//   saveRclSpikes_i                                      snapshot the whole recall bank into the learn bank
//   rdEn_LrnInSpike_i / LrnAxonAddr_i / Lrn_InSpike_o / Lrn_valid_o   learn bank read
//   spikeCnt_o                                           accepted in-range writes of the last completed timestep
module in_spike_buf_pp #(
  parameter int NUM_AXONS          = 256,
  parameter int AXON_CNT_BIT_WIDTH = 8,
  parameter int SPIKE_W            = 4,
  parameter int ACCUM_MODE         = 1,
  parameter int NUM_RCL_CH         = 2
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     start_i,
  output logic                                     busy_o,
  output logic                                     startErr_o,
  input  logic                                     wrEn_i,
  output logic                                     wrRdy_o,
  input  logic [AXON_CNT_BIT_WIDTH-1:0]            wrAxonAddr_i,
  input  logic [SPIKE_W-1:0]                       wrSpike_i,
  input  logic [NUM_RCL_CH-1:0]                    rdEn_RclInSpike_i,
  input  logic [NUM_RCL_CH*AXON_CNT_BIT_WIDTH-1:0] RclAxonAddr_i,
  output logic [NUM_RCL_CH*SPIKE_W-1:0]            Rcl_InSpike_o,
  output logic [NUM_RCL_CH-1:0]                    Rcl_valid_o,
  input  logic                                     saveRclSpikes_i,
  input  logic                                     rdEn_LrnInSpike_i,
  input  logic [AXON_CNT_BIT_WIDTH-1:0]            LrnAxonAddr_i,
  output logic [SPIKE_W-1:0]                       Lrn_InSpike_o,
  output logic                                     Lrn_valid_o,
  output logic [AXON_CNT_BIT_WIDTH:0]              spikeCnt_o
);

  localparam int AW = AXON_CNT_BIT_WIDTH;
  localparam int IW = (NUM_AXONS > 1) ? $clog2(NUM_AXONS) : 1;
  localparam int CW = AXON_CNT_BIT_WIDTH + 1;

  typedef enum logic {RUN, CLEAR} state_t;

  state_t              state;
  logic                bankSel;      // 0: fill = bank0, recall = bank1
  logic [IW-1:0]       clrAddr;
  logic [CW-1:0]       wrCnt;

  logic [SPIKE_W-1:0]  bank0   [NUM_AXONS];
  logic [SPIKE_W-1:0]  bank1   [NUM_AXONS];
  logic [SPIKE_W-1:0]  lrnBank [NUM_AXONS];

  logic                wrAcc;
  logic                wrHit;
  logic [IW-1:0]       wrIdx;
  logic [SPIKE_W-1:0]  fillOld;
  logic [SPIKE_W:0]    wrSum;
  logic [SPIKE_W-1:0]  wrNext;
  logic [CW-1:0]       cntNext;

  function automatic logic inRange(input logic [AW-1:0] a);
    return 32'(a) < NUM_AXONS;
  endfunction

  function automatic logic [SPIKE_W-1:0] recallAt(input logic [AW-1:0] a);
    if (!inRange(a))
      return '0;
    return bankSel ? bank0[a[IW-1:0]] : bank1[a[IW-1:0]];
  endfunction

  function automatic logic [SPIKE_W-1:0] learnAt(input logic [AW-1:0] a);
    if (!inRange(a))
      return '0;
    return lrnBank[a[IW-1:0]];
  endfunction

  // Out-of-range writes complete the handshake but are neither stored nor counted.
  always_comb begin
    wrAcc   = wrEn_i && wrRdy_o;
    wrHit   = wrAcc && inRange(wrAxonAddr_i);
    wrIdx   = wrAxonAddr_i[IW-1:0];
    fillOld = bankSel ? bank1[wrIdx] : bank0[wrIdx];
    wrSum   = {1'b0, fillOld} + {1'b0, wrSpike_i};
    wrNext  = wrSpike_i;
    if (ACCUM_MODE != 0)
      wrNext = wrSum[SPIKE_W] ? {SPIKE_W{1'b1}} : wrSum[SPIKE_W-1:0];
    cntNext = (wrHit && (wrCnt != {CW{1'b1}})) ? wrCnt + 1'b1 : wrCnt;
  end

  // Control FSM; wrRdy_o/busy_o are registered alongside the state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= RUN;
      bankSel    <= 1'b0;
      clrAddr    <= '0;
      wrCnt      <= '0;
      spikeCnt_o <= '0;
      wrRdy_o    <= 1'b1;
      busy_o     <= 1'b0;
      startErr_o <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (start_i) begin
            // A write accepted on this same edge is counted in the closing timestep.
            bankSel    <= ~bankSel;
            spikeCnt_o <= cntNext;
            wrCnt      <= '0;
            clrAddr    <= '0;
            state      <= CLEAR;
            wrRdy_o    <= 1'b0;
            busy_o     <= 1'b1;
          end else begin
            wrCnt <= cntNext;
          end
        end
        CLEAR: begin
          if (start_i)
            startErr_o <= 1'b1;
          clrAddr <= clrAddr + 1'b1;
          if (clrAddr == IW'(NUM_AXONS - 1)) begin
            clrAddr <= '0;
            state   <= RUN;
            wrRdy_o <= 1'b1;
            busy_o  <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Bank storage. The sweep and writes never overlap since writes stall during CLEAR.
  // Both select on bankSel as it stands before the edge, so a write coinciding
  // with start_i lands in the bank that is about to become recall.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_AXONS; i++) begin
        bank0[i]   <= '0;
        bank1[i]   <= '0;
        lrnBank[i] <= '0;
      end
    end else begin
      if (state == CLEAR) begin
        if (bankSel)
          bank1[clrAddr] <= '0;
        else
          bank0[clrAddr] <= '0;
      end
      if (wrHit) begin
        if (bankSel)
          bank1[wrIdx] <= wrNext;
        else
          bank0[wrIdx] <= wrNext;
      end
      if (saveRclSpikes_i) begin
        for (int i = 0; i < NUM_AXONS; i++)
          lrnBank[i] <= bankSel ? bank0[i] : bank1[i];
      end
    end
  end

  // Read ports: data registers hold their last value when not enabled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      Rcl_InSpike_o <= '0;
      Rcl_valid_o   <= '0;
      Lrn_InSpike_o <= '0;
      Lrn_valid_o   <= 1'b0;
    end else begin
      Rcl_valid_o <= rdEn_RclInSpike_i;
      for (int k = 0; k < NUM_RCL_CH; k++) begin
        if (rdEn_RclInSpike_i[k])
          Rcl_InSpike_o[k*SPIKE_W +: SPIKE_W] <= recallAt(RclAxonAddr_i[k*AW +: AW]);
      end
      Lrn_valid_o <= rdEn_LrnInSpike_i;
      if (rdEn_LrnInSpike_i)
        Lrn_InSpike_o <= learnAt(LrnAxonAddr_i);
    end
  end

endmodule

// File: tb/tb_in_spike_buf_pp.sv
// Bench for in_spike_buf_pp: directed scenarios then randomized timesteps,
// checked against a timestep-level model (clear sweep modelled as an instant wipe).
module tb_in_spike_buf_pp;

  localparam int NA  = 256;
  localparam int AW  = 9;
  localparam int SW  = 4;
  localparam int NCH = 2;
  localparam int SMAX = 15;
  localparam int CMAX = 1023;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic              startErr;
  logic              wrEn;
  logic              wrRdy;
  logic [AW-1:0]     wrAddr;
  logic [SW-1:0]     wrSpike;
  logic [NCH-1:0]    rdEn;
  logic [NCH*AW-1:0] rclAddr;
  logic [NCH*SW-1:0] rclDat;
  logic [NCH-1:0]    rclVld;
  logic              save;
  logic              lrnEn;
  logic [AW-1:0]     lrnAddr;
  logic [SW-1:0]     lrnDat;
  logic              lrnVld;
  logic [AW:0]       spikeCnt;

  int total = 0;
  int bad   = 0;

  // Reference model: banks indexed as [fill/recall slot], learn copy, counters.
  int mB [2][NA];
  int mL [NA];
  int mSel, mCnt, mSpk, mErr;
  int mRcl [NCH];
  int mLrn;

  in_spike_buf_pp #(
    .NUM_AXONS(NA), .AXON_CNT_BIT_WIDTH(AW), .SPIKE_W(SW), .ACCUM_MODE(1), .NUM_RCL_CH(NCH)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .startErr_o(startErr),
    .wrEn_i(wrEn), .wrRdy_o(wrRdy), .wrAxonAddr_i(wrAddr), .wrSpike_i(wrSpike),
    .rdEn_RclInSpike_i(rdEn), .RclAxonAddr_i(rclAddr), .Rcl_InSpike_o(rclDat), .Rcl_valid_o(rclVld),
    .saveRclSpikes_i(save), .rdEn_LrnInSpike_i(lrnEn), .LrnAxonAddr_i(lrnAddr),
    .Lrn_InSpike_o(lrnDat), .Lrn_valid_o(lrnVld), .spikeCnt_o(spikeCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    for (int i = 0; i < NA; i++) begin
      mB[0][i] = 0; mB[1][i] = 0; mL[i] = 0;
    end
    mSel = 0; mCnt = 0; mSpk = 0; mErr = 0; mLrn = 0;
    for (int k = 0; k < NCH; k++) mRcl[k] = 0;
  endtask

  function automatic int rclExp(input int a);
    return (a < NA) ? mB[1-mSel][a] : 0;
  endfunction

  function automatic int lrnExp(input int a);
    return (a < NA) ? mL[a] : 0;
  endfunction

  task automatic modelWrite(input int a, input int v);
    int s;
    if (a < NA) begin
      s = mB[mSel][a] + v;
      mB[mSel][a] = (s > SMAX) ? SMAX : s;
      mCnt = (mCnt < CMAX) ? mCnt + 1 : CMAX;
    end
  endtask

  task automatic modelSave();
    for (int i = 0; i < NA; i++) mL[i] = mB[1-mSel][i];
  endtask

  task automatic modelSwap();
    mSpk = mCnt;
    mCnt = 0;
    mSel = 1 - mSel;
    for (int i = 0; i < NA; i++) mB[mSel][i] = 0;
  endtask

  // Holds the request until wrRdy is seen; reports cycles spent waiting.
  task automatic doWrite(input int a, input int v, output int waited);
    logic [AW-1:0] av;
    av = a[AW-1:0];
    wrEn = 1'b1; wrAddr = av; wrSpike = v[SW-1:0];
    waited = 0;
    while (!wrRdy && waited < 1000) begin
      waited++;
      tick();
    end
    if (waited >= 1000) chk("wr_timeout", 32'(wrRdy), 1);
    tick();
    wrEn = 1'b0;
    modelWrite(a, v);
  endtask

  task automatic doStart();
    start = 1'b1;
    tick();
    start = 1'b0;
    modelSwap();
  endtask

  // Counts remaining busy cycles; pre = busy cycles already consumed by the caller.
  task automatic sweep(input int pre, input string tag);
    int n;
    n = 0;
    while (busy && n < 1000) begin
      n++;
      tick();
    end
    chk(tag, pre + n, NA);
    chk({tag, "_rdy"}, 32'(wrRdy), 1);
  endtask

  task automatic rdStep(input int e0, input int a0, input int e1, input int a1,
                        input int le, input int la, input int sv);
    logic [AW-1:0] a0v, a1v, lav;
    a0v = a0[AW-1:0]; a1v = a1[AW-1:0]; lav = la[AW-1:0];
    if (e0 != 0) mRcl[0] = rclExp(a0);
    if (e1 != 0) mRcl[1] = rclExp(a1);
    if (le != 0) mLrn = lrnExp(la);
    rdEn = {e1[0], e0[0]};
    rclAddr = {a1v, a0v};
    lrnEn = le[0]; lrnAddr = lav; save = sv[0];
    tick();
    rdEn = '0; lrnEn = 1'b0; save = 1'b0;
    if (sv != 0) modelSave();
    chk("rcl_vld0", 32'(rclVld[0]), 32'(e0 != 0));
    chk("rcl_vld1", 32'(rclVld[1]), 32'(e1 != 0));
    chk("rcl_dat0", 32'(rclDat[SW-1:0]), mRcl[0]);
    chk("rcl_dat1", 32'(rclDat[2*SW-1:SW]), mRcl[1]);
    chk("lrn_vld", 32'(lrnVld), 32'(le != 0));
    chk("lrn_dat", 32'(lrnDat), mLrn);
  endtask

  function automatic int rndAddr();
    return ($urandom_range(0, 9) == 0) ? $urandom_range(NA, 511) : $urandom_range(0, 31);
  endfunction

  initial begin
    int w, n;
    rst = 1'b1; start = 0; wrEn = 0; wrAddr = '0; wrSpike = '0;
    rdEn = '0; rclAddr = '0; save = 0; lrnEn = 0; lrnAddr = '0;
    modelReset();
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_wrRdy", 32'(wrRdy), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_startErr", 32'(startErr), 0);
    chk("rst_spikeCnt", 32'(spikeCnt), 0);
    chk("rst_rclVld", 32'(rclVld), 0);
    chk("rst_rclDat", 32'(rclDat), 0);
    chk("rst_lrnVld", 32'(lrnVld), 0);
    rdStep(1, 5, 0, 0, 0, 0, 0);
    chk("rst_read5", 32'(rclDat[SW-1:0]), 0);

    // Saturating accumulate, out-of-range write discarded
    doWrite(3, 9, w);
    doWrite(3, 9, w);
    doWrite(10, 6, w);
    doWrite(300, 5, w);
    doStart();
    sweep(0, "busy_len_accum");
    chk("spikeCnt_accum", 32'(spikeCnt), 3);
    rdStep(1, 3, 1, 10, 0, 0, 0);
    chk("sat_addr3", 32'(rclDat[SW-1:0]), 15);
    // In-range and out-of-range channels in one cycle, then same address on both
    rdStep(1, 10, 1, 300, 0, 0, 0);
    chk("oor_ch1", 32'(rclDat[2*SW-1:SW]), 0);
    rdStep(1, 10, 1, 10, 0, 0, 0);
    // Data holds with enable low
    rdStep(0, 3, 0, 3, 0, 0, 0);

    // Backpressure: a write held across the whole sweep is accepted exactly once
    doStart();
    doWrite(20, 3, w);
    chk("bp_wait", w, NA);
    doStart();
    sweep(0, "busy_len_bp");
    chk("spikeCnt_bp", 32'(spikeCnt), 1);
    rdStep(1, 20, 0, 0, 0, 0, 0);
    chk("bp_addr20", 32'(rclDat[SW-1:0]), 3);

    // start during CLEAR is ignored and flagged
    doWrite(40, 11, w);
    doStart();
    n = 0;
    repeat (10) begin
      if (busy) n++;
      tick();
    end
    start = 1'b1;
    if (busy) n++;
    tick();
    start = 1'b0;
    mErr = 1;
    chk("startErr_set", 32'(startErr), mErr);
    sweep(n, "busy_len_err");
    rdStep(1, 40, 0, 0, 0, 0, 0);
    chk("err_nosel", 32'(rclDat[SW-1:0]), 11);

    // Write + start + save in one cycle
    doWrite(7, 2, w);
    doStart();
    sweep(0, "busy_len_pre");
    chk("pre_wrRdy", 32'(wrRdy), 1);
    wrEn = 1'b1; wrAddr = 9'd7; wrSpike = 4'd4; start = 1'b1; save = 1'b1;
    tick();
    wrEn = 1'b0; start = 1'b0; save = 1'b0;
    modelSave();
    modelWrite(7, 4);
    modelSwap();
    sweep(0, "busy_len_comb");
    chk("spikeCnt_comb", 32'(spikeCnt), mSpk);
    rdStep(1, 7, 0, 0, 1, 7, 0);
    chk("comb_rcl7", 32'(rclDat[SW-1:0]), 4);
    chk("comb_lrn7", 32'(lrnDat), 2);
    chk("startErr_sticky", 32'(startErr), mErr);

    // Randomized timesteps, including reads during the sweep and save+learn-read collisions
    for (int t = 0; t < 6; t++) begin
      for (int j = 0; j < 25; j++) begin
        if ($urandom_range(0, 3) != 0)
          doWrite(rndAddr(), $urandom_range(0, SMAX), w);
        else
          rdStep($urandom_range(0, 1), rndAddr(), $urandom_range(0, 1), rndAddr(),
                 $urandom_range(0, 1), rndAddr(), $urandom_range(0, 1));
      end
      doStart();
      for (int j = 0; j < 5; j++)
        rdStep($urandom_range(0, 1), rndAddr(), $urandom_range(0, 1), rndAddr(),
               $urandom_range(0, 1), rndAddr(), $urandom_range(0, 1));
      sweep(5, "busy_len_rand");
      chk("spikeCnt_rand", 32'(spikeCnt), mSpk);
      for (int a = 0; a < 32; a += 2)
        rdStep(1, a, 1, a + 1, 1, a, 0);
    end

    // Reset in the middle of a sweep
    doStart();
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    modelReset();
    tick();
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_wrRdy", 32'(wrRdy), 1);
    chk("midrst_startErr", 32'(startErr), 0);
    chk("midrst_spikeCnt", 32'(spikeCnt), 0);
    rdStep(1, 3, 1, 20, 1, 7, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
